axi4s_upsizer: RTL and testbench

//  Downstream stage of the AXI4-S sync FIFO: drains narrow tuser beats and packs

---
 rtl/axi4s_upsizer_if.sv | 38 +++
 rtl/axi4s_upsizer.sv | 133 +++++++++++++
 tb/tb_axi4s_upsizer.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/axi4s_upsizer_if.sv
// Stream bundle for axi4s_upsizer: narrow input beats on the axi4s_i_* side
// and packed wide words on the axi4s_o_* side.
// slave modport  = the upsizer's view.
// master modport = the environment's view (FIFO upstream, wide consumer downstream).
interface axi4s_upsizer_if #(
  parameter int tuser_bit_width_p = 8,
  parameter int pack_ratio_p      = 4
);
  localparam int count_width_lp = $clog2(pack_ratio_p + 1);

  logic                                      axi4s_i_tready;
  logic [tuser_bit_width_p-1:0]              axi4s_i_tuser;
  logic                                      axi4s_i_tvalid;
  logic                                      axi4s_o_tready;
  logic [pack_ratio_p*tuser_bit_width_p-1:0] axi4s_o_tuser;
  logic                                      axi4s_o_tvalid;
  logic [count_width_lp-1:0]                 axi4s_o_tcount;

  modport slave (
    output axi4s_i_tready,
    input  axi4s_i_tuser,
    input  axi4s_i_tvalid,
    input  axi4s_o_tready,
    output axi4s_o_tuser,
    output axi4s_o_tvalid,
    output axi4s_o_tcount
  );

  modport master (
    input  axi4s_i_tready,
    output axi4s_i_tuser,
    output axi4s_i_tvalid,
    output axi4s_o_tready,
    input  axi4s_o_tuser,
    input  axi4s_o_tvalid,
    input  axi4s_o_tcount
  );
endinterface

// File: rtl/axi4s_upsizer.sv
// axi4s_upsizer: packs pack_ratio_p narrow beats into one wide AXI4-S beat.
// The accumulator collects lanes while the output register holds the previous
// word, so one input beat per cycle is sustained.
// Optional feature macro: AXI4S_UPSIZER_TIMEOUT_EN adds an idle timer that
// flushes a partially filled word after cr_timeout idle cycles.
module axi4s_upsizer #(
  parameter int tuser_bit_width_p = 8,
  parameter int pack_ratio_p      = 4,
  parameter int timeout_width_p   = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  axi4s_upsizer_if.slave             bus,
  input  logic [timeout_width_p-1:0] cr_timeout,
  output logic [31:0]                sr_word_count
);
  localparam int cw_lp = $clog2(pack_ratio_p + 1);
  localparam int ww_lp = pack_ratio_p * tuser_bit_width_p;

  typedef enum logic {OUT_FREE, OUT_HELD} out_state_t;

  out_state_t       out_state, out_state_next;
  logic [cw_lp-1:0] lane_cnt;
  logic [ww_lp-1:0] accumulator, acc_next;
  logic [ww_lp-1:0] o_tuser_q;
  logic [cw_lp-1:0] o_tcount_q;

  logic in_xfer, out_xfer, out_free, last_lane;
  logic full_load, flush_load, load;

  assign last_lane = (lane_cnt == cw_lp'(pack_ratio_p - 1));
  assign out_xfer  = bus.axi4s_o_tvalid && bus.axi4s_o_tready;
  assign out_free  = !bus.axi4s_o_tvalid || bus.axi4s_o_tready;

  // The last lane may only enter when the output register can take the word.
  assign bus.axi4s_i_tready = !rst && !(last_lane && bus.axi4s_o_tvalid && !bus.axi4s_o_tready);
  assign in_xfer   = bus.axi4s_i_tvalid && bus.axi4s_i_tready;
  assign full_load = in_xfer && last_lane;
  assign load      = full_load || flush_load;

  assign bus.axi4s_o_tvalid = (out_state == OUT_HELD);
  assign bus.axi4s_o_tuser  = o_tuser_q;
  assign bus.axi4s_o_tcount = o_tcount_q;

`ifdef AXI4S_UPSIZER_TIMEOUT_EN
  logic [timeout_width_p-1:0] timer;
  logic                       timeout_hit;

  // Using >= keeps a match alive if cr_timeout is lowered below the timer.
  assign timeout_hit = (cr_timeout != '0) && (timer >= cr_timeout);
  assign flush_load  = timeout_hit && !in_xfer && (lane_cnt != '0) && out_free;

  // Idle timer: counts stalled cycles of a partial word, saturates at the limit.
  always_ff @(posedge clk) begin
    if (rst) begin
      timer <= '0;
    end else if (in_xfer || (lane_cnt == '0) || flush_load) begin
      timer <= '0;
    end else if (timer < cr_timeout) begin
      timer <= timer + 1'b1;
    end
  end
`else
  logic unused_cr_timeout;

  assign flush_load        = 1'b0;
  assign unused_cr_timeout = |cr_timeout;
`endif

  // Accumulator with the current beat merged into its lane.
  always_comb begin
    acc_next = accumulator;
    if (in_xfer) begin
      acc_next[int'(lane_cnt)*tuser_bit_width_p +: tuser_bit_width_p] = bus.axi4s_i_tuser;
    end
  end

  // Lane counter and accumulator: fill lane by lane, restart empty after a load.
  always_ff @(posedge clk) begin
    if (rst) begin
      lane_cnt    <= '0;
      accumulator <= '0;
    end else if (load) begin
      lane_cnt    <= '0;
      accumulator <= '0;
    end else if (in_xfer) begin
      lane_cnt    <= lane_cnt + 1'b1;
      accumulator <= acc_next;
    end
  end

  // Output register data: captured on a full or flushed word, otherwise stable.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_tuser_q  <= '0;
      o_tcount_q <= '0;
    end else if (full_load) begin
      o_tuser_q  <= acc_next;
      o_tcount_q <= cw_lp'(pack_ratio_p);
    end else if (flush_load) begin
      o_tuser_q  <= accumulator;
      o_tcount_q <= lane_cnt;
    end
  end

  // Output register state flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_state <= OUT_FREE;
    end else begin
      out_state <= out_state_next;
    end
  end

  // A new load wins over a drain, so back-to-back words leave no bubble.
  always_comb begin
    out_state_next = out_state;
    if (load) begin
      out_state_next = OUT_HELD;
    end else if (out_xfer) begin
      out_state_next = OUT_FREE;
    end
  end

  // Delivered wide-word counter; wraps naturally at 32 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_word_count <= '0;
    end else if (out_xfer) begin
      sr_word_count <= sr_word_count + 32'd1;
    end
  end
endmodule

// File: tb/tb_axi4s_upsizer.sv
// Directed bench for axi4s_upsizer (W=8, ratio=4, timeout width 8).
// Timeout scenarios run when AXI4S_UPSIZER_TIMEOUT_EN is defined,
// the hold-forever scenario otherwise.
module tb_axi4s_upsizer;
  logic        clk;
  logic        rst;
  logic [7:0]  cr_timeout;
  logic [31:0] sr_word_count;

  int n_checks = 0;
  int n_fail   = 0;

  axi4s_upsizer_if #(.tuser_bit_width_p(8), .pack_ratio_p(4)) bus ();

  axi4s_upsizer #(
    .tuser_bit_width_p(8),
    .pack_ratio_p(4),
    .timeout_width_p(8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .cr_timeout    (cr_timeout),
    .sr_word_count (sr_word_count)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive the input beat and let combinational outputs settle.
  task automatic applyStimulus(input logic valid, input logic [7:0] data);
    bus.axi4s_i_tvalid = valid;
    bus.axi4s_i_tuser  = data;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  initial begin : main
    logic [31:0] exp_word;
    int          words_seen;
    int          ready_low;
    int          valid_seen;

    rst                = 1'b1;
    cr_timeout         = 8'd0;
    bus.axi4s_o_tready = 1'b0;
    applyStimulus(1'b0, 8'h00);

    // Reset state
    step();
    checkOutput("rst_i_tready", 64'(bus.axi4s_i_tready), 64'd0);
    checkOutput("rst_o_tvalid", 64'(bus.axi4s_o_tvalid), 64'd0);
    checkOutput("rst_o_tuser",  64'(bus.axi4s_o_tuser),  64'd0);
    checkOutput("rst_o_tcount", 64'(bus.axi4s_o_tcount), 64'd0);
    checkOutput("rst_words",    64'(sr_word_count),      64'd0);
    step();
    rst = 1'b0;
    #1;

    // Scenario 1: one word, latency and count
    $display("[TB] scenario 1: single word");
    bus.axi4s_o_tready = 1'b1;
    applyStimulus(1'b1, 8'h11); step();
    applyStimulus(1'b1, 8'h22); step();
    applyStimulus(1'b1, 8'h33); step();
    checkOutput("t1_no_early_valid", 64'(bus.axi4s_o_tvalid), 64'd0);
    applyStimulus(1'b1, 8'h44);
    checkOutput("t1_i_tready", 64'(bus.axi4s_i_tready), 64'd1);
    step();
    checkOutput("t1_o_tvalid", 64'(bus.axi4s_o_tvalid), 64'd1);
    checkOutput("t1_o_tuser",  64'(bus.axi4s_o_tuser),  64'h44332211);
    checkOutput("t1_o_tcount", 64'(bus.axi4s_o_tcount), 64'd4);
    applyStimulus(1'b0, 8'h00);
    step();
    checkOutput("t1_words",      64'(sr_word_count),      64'd1);
    checkOutput("t1_valid_drop", 64'(bus.axi4s_o_tvalid), 64'd0);

    // Scenario 2: 64 back-to-back beats
    $display("[TB] scenario 2: streaming");
    words_seen = 0;
    ready_low  = 0;
    for (int k = 0; k < 64; k++) begin
      applyStimulus(1'b1, 8'(k));
      if (bus.axi4s_i_tready !== 1'b1) ready_low++;
      step();
      if (bus.axi4s_o_tvalid === 1'b1) begin
        exp_word = '0;
        for (int b = 0; b < 4; b++) exp_word[b*8 +: 8] = 8'(4*words_seen + b);
        checkOutput("t2_word", 64'(bus.axi4s_o_tuser), 64'(exp_word));
        words_seen++;
      end
    end
    applyStimulus(1'b0, 8'h00);
    step();
    checkOutput("t2_ready_low", 64'(ready_low),     64'd0);
    checkOutput("t2_word_cnt",  64'(words_seen),    64'd16);
    checkOutput("t2_words",     64'(sr_word_count), 64'd17);

    // Scenario 3: backpressure on the last lane
    $display("[TB] scenario 3: backpressure");
    bus.axi4s_o_tready = 1'b0;
    for (int k = 0; k < 7; k++) begin
      applyStimulus(1'b1, 8'(8'h50 + k));
      step();
    end
    checkOutput("t3_held_valid", 64'(bus.axi4s_o_tvalid), 64'd1);
    checkOutput("t3_held_word",  64'(bus.axi4s_o_tuser),  64'h53525150);
    applyStimulus(1'b1, 8'h57);
    checkOutput("t3_stall", 64'(bus.axi4s_i_tready), 64'd0);
    step(); step(); step();
    checkOutput("t3_still_stall", 64'(bus.axi4s_i_tready), 64'd0);
    checkOutput("t3_still_word",  64'(bus.axi4s_o_tuser),  64'h53525150);
    bus.axi4s_o_tready = 1'b1;
    #1;
    checkOutput("t3_release", 64'(bus.axi4s_i_tready), 64'd1);
    step();
    checkOutput("t3_second_valid", 64'(bus.axi4s_o_tvalid), 64'd1);
    checkOutput("t3_second_word",  64'(bus.axi4s_o_tuser),  64'h57565554);
    checkOutput("t3_words_a",      64'(sr_word_count),      64'd18);
    applyStimulus(1'b0, 8'h00);
    step();
    checkOutput("t3_words_b", 64'(sr_word_count),      64'd19);
    checkOutput("t3_drained", 64'(bus.axi4s_o_tvalid), 64'd0);

    // Scenario 4: reset in the middle of a word
    $display("[TB] scenario 4: mid-word reset");
    applyStimulus(1'b1, 8'hEE); step();
    applyStimulus(1'b1, 8'hEF); step();
    rst = 1'b1;
    applyStimulus(1'b0, 8'h00);
    step();
    checkOutput("t4_words_rst",   64'(sr_word_count),       64'd0);
    checkOutput("t4_i_tready_rst", 64'(bus.axi4s_i_tready), 64'd0);
    rst = 1'b0;
    #1;
    applyStimulus(1'b1, 8'hA1); step();
    applyStimulus(1'b1, 8'hA2); step();
    applyStimulus(1'b1, 8'hA3); step();
    applyStimulus(1'b1, 8'hA4); step();
    checkOutput("t4_word",   64'(bus.axi4s_o_tuser),  64'hA4A3A2A1);
    checkOutput("t4_tcount", 64'(bus.axi4s_o_tcount), 64'd4);
    applyStimulus(1'b0, 8'h00);
    step();
    checkOutput("t4_words", 64'(sr_word_count), 64'd1);

`ifdef AXI4S_UPSIZER_TIMEOUT_EN
    // Scenario 5: partial flush after idle timeout
    $display("[TB] scenario 5: timeout flush");
    cr_timeout = 8'd5;
    applyStimulus(1'b1, 8'hAA); step();
    applyStimulus(1'b1, 8'hBB); step();
    applyStimulus(1'b1, 8'hCC); step();
    applyStimulus(1'b0, 8'h00);
    valid_seen = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      if (bus.axi4s_o_tvalid === 1'b1) valid_seen++;
    end
    checkOutput("t5_no_early_flush", 64'(valid_seen), 64'd0);
    step();
    checkOutput("t5_flush_valid",  64'(bus.axi4s_o_tvalid), 64'd1);
    checkOutput("t5_flush_word",   64'(bus.axi4s_o_tuser),  64'h00CCBBAA);
    checkOutput("t5_flush_tcount", 64'(bus.axi4s_o_tcount), 64'd3);
    step();

    // Beat arriving on the match cycle wins over the flush
    applyStimulus(1'b1, 8'h01); step();
    applyStimulus(1'b1, 8'h02); step();
    applyStimulus(1'b0, 8'h00);
    for (int k = 0; k < 5; k++) step();
    applyStimulus(1'b1, 8'h03);
    step();
    applyStimulus(1'b0, 8'h00);
    checkOutput("t5_beat_wins", 64'(bus.axi4s_o_tvalid), 64'd0);
    valid_seen = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      if (bus.axi4s_o_tvalid === 1'b1) valid_seen++;
    end
    checkOutput("t5_timer_restart", 64'(valid_seen), 64'd0);
    step();
    checkOutput("t5_flush2_valid",  64'(bus.axi4s_o_tvalid), 64'd1);
    checkOutput("t5_flush2_word",   64'(bus.axi4s_o_tuser),  64'h00030201);
    checkOutput("t5_flush2_tcount", 64'(bus.axi4s_o_tcount), 64'd3);
    step();
`else
    // Scenario 6: no timer, partial word held indefinitely
    $display("[TB] scenario 6: no timeout");
    cr_timeout = 8'd5;
    applyStimulus(1'b1, 8'h31); step();
    applyStimulus(1'b1, 8'h32); step();
    applyStimulus(1'b1, 8'h33); step();
    applyStimulus(1'b0, 8'h00);
    valid_seen = 0;
    for (int k = 0; k < 100; k++) begin
      step();
      if (bus.axi4s_o_tvalid !== 1'b0) valid_seen++;
    end
    checkOutput("t6_no_flush", 64'(valid_seen), 64'd0);
    applyStimulus(1'b1, 8'h34);
    step();
    applyStimulus(1'b0, 8'h00);
    checkOutput("t6_word",   64'(bus.axi4s_o_tuser),  64'h34333231);
    checkOutput("t6_tcount", 64'(bus.axi4s_o_tcount), 64'd4);
    step();
    checkOutput("t6_words", 64'(sr_word_count), 64'd2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
